// File: rtl/sample_serializer.sv
// sample_serializer
//
// Accepts one parallel frame of NR_CHANNELS samples and emits it one sample
// at a time, channel 0 first, each as a single-cycle vm_signal_dv pulse
// followed by DV_GAP idle cycles. A frame counter produces a vm_sync pulse,
// coincident with the last-channel sample, once every SYNC_INTERVAL frames.
//
// Handshake: a frame is transferred in a cycle where fr_dv and fr_ready are
// both high; fr_ready is high only while the serializer is idle and not in
// reset, and fr_dv while fr_ready is low has no effect.
//
// Optional feature: define SAMPLE_SERIALIZER_MUTE_EN to zero vm_signal_d for
// samples emitted while mute is high. Without it mute is ignored.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   fr_d          parallel frame, channel k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   fr_dv         frame valid
//   fr_ready      frame accept (idle)
//   mute          zero outgoing sample data (only with the mute feature)
//   vm_signal_d   serialized sample, held between pulses
//   vm_signal_ch  channel index of the sample, held between pulses
//   vm_signal_dv  sample valid pulse
//   vm_sync       metering-period sync pulse
module sample_serializer #(
  parameter int NR_CHANNELS   = 3,
  parameter int INPUT_WIDTH   = 24,
  parameter int SYNC_INTERVAL = 3,
  parameter int DV_GAP        = 1,
  localparam int CHW = (NR_CHANNELS < 2) ? 1 : $clog2(NR_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NR_CHANNELS*INPUT_WIDTH-1:0] fr_d,
  input  logic                               fr_dv,
  output logic                               fr_ready,
  input  logic                               mute,
  output logic [INPUT_WIDTH-1:0]             vm_signal_d,
  output logic [CHW-1:0]                     vm_signal_ch,
  output logic                               vm_signal_dv,
  output logic                               vm_sync
);

  localparam int GW = (DV_GAP < 3) ? 1 : $clog2(DV_GAP);
  localparam int SW = (SYNC_INTERVAL < 2) ? 1 : $clog2(SYNC_INTERVAL);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NR_CHANNELS - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'((DV_GAP > 0) ? DV_GAP - 1 : 0);
  localparam logic [SW-1:0]  SYNC_LAST = SW'(SYNC_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t                             state_q, state_d;
  logic [NR_CHANNELS*INPUT_WIDTH-1:0] buf_q;
  logic [CHW-1:0]                     ch_q, ch_d;
  logic [GW-1:0]                      gap_q, gap_d;
  logic [SW-1:0]                      frame_q;
  logic [INPUT_WIDTH-1:0]             hold_q;
  logic [INPUT_WIDTH-1:0]             sample;
  logic [INPUT_WIDTH-1:0]             emit_d;
  logic                               last_ch;

  assign last_ch = (ch_q == CH_LAST);

  // Next-state logic. ch_q points at the channel being (or last) emitted and
  // only advances when the next EMIT is entered, so it doubles as the held
  // vm_signal_ch value between pulses.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (fr_dv) begin
          state_d = EMIT;
          ch_d    = '0;
        end
      end
      EMIT: begin
        gap_d = '0;
        if (DV_GAP > 0) begin
          state_d = GAP;
        end else if (last_ch) begin
          state_d = IDLE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (last_ch) begin
            state_d = IDLE;
          end else begin
            state_d = EMIT;
            ch_d    = ch_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the buffered sample for the current channel.
  always_comb begin
    sample = '0;
    for (int k = 0; k < NR_CHANNELS; k++) begin
      if (ch_q == CHW'(k)) sample = buf_q[k*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

`ifdef SAMPLE_SERIALIZER_MUTE_EN
  assign emit_d = mute ? '0 : sample;
`else
  logic unused_mute;
  assign unused_mute = mute;
  assign emit_d      = sample;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      gap_q   <= '0;
      frame_q <= '0;
      buf_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      gap_q   <= gap_d;
      if (state_q == IDLE && fr_dv) buf_q <= fr_d;
      if (state_q == EMIT) begin
        // Remember what was actually emitted (muted or not) for the hold.
        hold_q <= emit_d;
        if (last_ch) frame_q <= (frame_q == SYNC_LAST) ? '0 : frame_q + 1'b1;
      end
    end
  end

  // rst gates fr_ready so it drops the moment reset is applied.
  assign fr_ready     = (state_q == IDLE) && !rst;
  assign vm_signal_dv = (state_q == EMIT);
  assign vm_signal_ch = ch_q;
  assign vm_signal_d  = vm_signal_dv ? emit_d : hold_q;
  assign vm_sync      = vm_signal_dv && last_ch && (frame_q == SYNC_LAST);

endmodule

// File: tb/tb_sample_serializer.sv
// Testbench for sample_serializer: default-parameter instance checked every
// cycle against a timing model of the frame schedule, plus a single-channel
// no-gap instance checked against its simple alternating pattern.
module tb_sample_serializer;

  localparam int NR     = 3;
  localparam int W      = 24;
  localparam int SYNC   = 3;
  localparam int G      = 1;
  localparam int PERIOD = NR * (1 + G) + 1;
`ifdef SAMPLE_SERIALIZER_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 0: defaults
  logic [NR*W-1:0] fr_d  = '0;
  logic            fr_dv = 1'b0;
  logic            mute  = 1'b0;
  logic            fr_ready, vm_signal_dv, vm_sync;
  logic [W-1:0]    vm_signal_d;
  logic [1:0]      vm_signal_ch;

  sample_serializer #(.NR_CHANNELS(NR), .INPUT_WIDTH(W), .SYNC_INTERVAL(SYNC), .DV_GAP(G)) dut (
    .clk(clk), .rst(rst), .fr_d(fr_d), .fr_dv(fr_dv), .fr_ready(fr_ready), .mute(mute),
    .vm_signal_d(vm_signal_d), .vm_signal_ch(vm_signal_ch), .vm_signal_dv(vm_signal_dv),
    .vm_sync(vm_sync)
  );

  // DUT 1: one channel, no gap, sync every frame
  logic [W-1:0] fr_d1  = '0;
  logic         fr_dv1 = 1'b0;
  logic         mute1  = 1'b0;
  logic         fr_ready1, dv1, sync1;
  logic [W-1:0] d1;
  logic [0:0]   ch1;

  sample_serializer #(.NR_CHANNELS(1), .INPUT_WIDTH(W), .SYNC_INTERVAL(1), .DV_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .fr_d(fr_d1), .fr_dv(fr_dv1), .fr_ready(fr_ready1), .mute(mute1),
    .vm_signal_d(d1), .vm_signal_ch(ch1), .vm_signal_dv(dv1), .vm_sync(sync1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard queue of expected sample values
  logic [W-1:0] exp_q[$];

  // reference model state: one frame in flight, scheduled by arithmetic
  bit          have_frame = 1'b0;
  int          cur_a      = 0;
  logic [NR*W-1:0] cur_d  = '0;
  int          cur_idx    = 0;
  int          frame_idx  = 0;
  logic [1:0]  last_ch    = '0;
  logic [W-1:0] last_d    = '0;
  bit          exp_ready, exp_dv, exp_sync;

  function automatic logic [NR*W-1:0] rand_frame();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[NR*W-1:0];
  endfunction

  // driver: step to just after the rising edge where inputs are applied
  task automatic begin_cycle();
    @(posedge clk);
    #1;
  endtask

  // model: at mid-cycle, derive expected outputs for this cycle from the
  // accepted frame's start cycle, then decide acceptance of this cycle's frame
  task automatic model_cycle();
    int off, k;
    @(negedge clk);
    exp_dv   = 1'b0;
    exp_sync = 1'b0;
    if (rst) begin
      have_frame = 1'b0;
      frame_idx  = 0;
      last_ch    = '0;
      last_d     = '0;
      exp_ready  = 1'b0;
    end else begin
      if (have_frame) begin
        off = cyc - cur_a - 1;
        if (off >= 0 && (off % (1 + G)) == 0 && (off / (1 + G)) < NR) begin
          k        = off / (1 + G);
          exp_dv   = 1'b1;
          last_ch  = 2'(k);
          last_d   = (MUTE_EN && mute) ? '0 : cur_d[k*W +: W];
          exp_sync = (k == NR - 1) && ((cur_idx % SYNC) == SYNC - 1);
        end
      end
      exp_ready = !have_frame || (cyc >= cur_a + PERIOD);
      if (exp_ready && fr_dv) begin
        have_frame = 1'b1;
        cur_a      = cyc;
        cur_d      = fr_d;
        cur_idx    = frame_idx;
        frame_idx++;
      end
    end
  endtask

  task automatic test_reset();
    begin_cycle();
    rst = 1'b1;
    model_cycle();
    n_checks++;
    if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== 29'd0) begin
      n_errors++;
      $display("FAIL reset_outputs cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected all zero",
               cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d);
    end
    begin_cycle();
    rst = 1'b0;
    model_cycle();
    n_checks++;
    if (fr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready cyc=%0d got %b expected 1", cyc, fr_ready);
    end
  endtask

  task automatic test_known_frame();
    int a, k;
    logic [W-1:0] e;
    begin_cycle();
    fr_dv = 1'b1;
    fr_d  = {24'h800000, 24'h7FFFFF, 24'h000001};
    model_cycle();
    a = cyc;
    exp_q.push_back(24'h000001);
    exp_q.push_back(24'h7FFFFF);
    exp_q.push_back(24'h800000);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        begin_cycle();
        fr_dv = 1'b0;
        model_cycle();
      end
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL known_frame cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
      if (vm_signal_dv === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL known_frame_extra_pulse cyc=%0d got d=%h expected no pulse", cyc, vm_signal_d);
        end else begin
          e = exp_q.pop_front();
          if (vm_signal_d !== e || vm_signal_ch !== 2'(k) || cyc != a + 1 + 2 * k) begin
            n_errors++;
            $display("FAIL known_frame_pulse got d=%h ch=%0d at A+%0d expected d=%h ch=%0d at A+%0d",
                     vm_signal_d, vm_signal_ch, cyc - a, e, k, 1 + 2 * k);
          end
          k++;
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL known_frame_missing got %0d pulses expected 3", k);
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int n_sync, sync_cyc, a1, a3;
    begin_cycle();
    rst = 1'b1;
    model_cycle();
    begin_cycle();
    rst = 1'b0;
    model_cycle();
    n_sync = 0; sync_cyc = -1; a1 = -1; a3 = -1;
    for (int i = 0; i < 40; i++) begin
      begin_cycle();
      fr_dv = (frame_idx < 3);
      fr_d  = rand_frame();
      model_cycle();
      if (frame_idx == 1 && a1 < 0) a1 = cur_a;
      if (frame_idx == 3 && a3 < 0) a3 = cur_a;
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL back_to_back cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
      if (vm_sync === 1'b1) begin
        n_sync++;
        sync_cyc = cyc;
      end
      if (a3 >= 0 && cyc > a3 + PERIOD) break;
    end
    fr_dv = 1'b0;
    n_checks++;
    if (a3 < 0 || a3 - a1 != 2 * PERIOD) begin
      n_errors++;
      $display("FAIL back_to_back_period got frame1->frame3 spacing %0d expected %0d", a3 - a1, 2 * PERIOD);
    end
    n_checks++;
    if (n_sync != 1 || sync_cyc != a3 + 1 + (NR - 1) * (1 + G)) begin
      n_errors++;
      $display("FAIL back_to_back_sync got %0d pulses last at cyc %0d expected 1 at cyc %0d",
               n_sync, sync_cyc, a3 + 1 + (NR - 1) * (1 + G));
    end
  endtask

  task automatic test_mute();
    int a;
    logic [NR*W-1:0] f;
    logic [W-1:0] e;
    f = rand_frame();
    begin_cycle();
    fr_dv = 1'b1;
    fr_d  = f;
    model_cycle();
    a = cyc;
    for (int i = 0; i < 8; i++) begin
      begin_cycle();
      fr_dv = 1'b0;
      mute  = (cyc == a + 3);
      model_cycle();
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL mute cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
      if (vm_signal_dv === 1'b1) begin
        e = (MUTE_EN && vm_signal_ch == 2'd1) ? '0 : f[vm_signal_ch*W +: W];
        n_checks++;
        if (vm_signal_d !== e) begin
          n_errors++;
          $display("FAIL mute_data ch=%0d got %h expected %h", vm_signal_ch, vm_signal_d, e);
        end
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int a, n_dv_cut, n_sync, first_ch;
    begin_cycle();
    fr_dv = 1'b1;
    fr_d  = rand_frame();
    model_cycle();
    a = cyc;
    n_dv_cut = 0;
    for (int i = 0; i < 6; i++) begin
      begin_cycle();
      fr_dv = 1'b0;
      rst   = (cyc == a + 3) || (cyc == a + 4);
      model_cycle();
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL reset_mid_frame cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
      if (cyc >= a + 3 && vm_signal_dv === 1'b1) n_dv_cut++;
    end
    n_checks++;
    if (n_dv_cut != 0) begin
      n_errors++;
      $display("FAIL reset_mid_frame_cut got %0d pulses after reset expected 0", n_dv_cut);
    end
    n_sync = 0; first_ch = -1;
    for (int i = 0; i < 40; i++) begin
      begin_cycle();
      fr_dv = (frame_idx < 3);
      fr_d  = rand_frame();
      model_cycle();
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL reset_restart cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
      if (vm_signal_dv === 1'b1 && first_ch < 0) first_ch = int'(vm_signal_ch);
      if (vm_sync === 1'b1) n_sync++;
      if (frame_idx == 3 && cyc > cur_a + PERIOD) break;
    end
    fr_dv = 1'b0;
    n_checks++;
    if (first_ch != 0 || n_sync != 1) begin
      n_errors++;
      $display("FAIL reset_restart_summary got first ch %0d and %0d syncs expected ch 0 and 1 sync", first_ch, n_sync);
    end
  endtask

  task automatic test_ignore_dv();
    int a;
    logic [NR*W-1:0] f;
    f = rand_frame();
    begin_cycle();
    fr_dv = 1'b1;
    fr_d  = f;
    model_cycle();
    a = cyc;
    for (int k = 0; k < NR; k++) exp_q.push_back(f[k*W +: W]);
    for (int i = 0; i < 9; i++) begin
      begin_cycle();
      fr_dv = (cyc <= a + 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      fr_d  = rand_frame();
      model_cycle();
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL ignore_dv cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
      if (vm_signal_dv === 1'b1 && exp_q.size() > 0) begin
        n_checks++;
        if (vm_signal_d !== exp_q[0]) begin
          n_errors++;
          $display("FAIL ignore_dv_data got %h expected %h", vm_signal_d, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL ignore_dv_missing got %0d samples short expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      begin_cycle();
      rst   = ($urandom_range(0, 99) == 0);
      fr_dv = 1'($urandom_range(0, 1));
      mute  = ($urandom_range(0, 3) == 0);
      fr_d  = rand_frame();
      model_cycle();
      n_checks++;
      if ({fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d} !== {exp_ready, exp_dv, exp_sync, last_ch, last_d}) begin
        n_errors++;
        $display("FAIL random cyc=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=%0d d=%h",
                 cyc, fr_ready, vm_signal_dv, vm_sync, vm_signal_ch, vm_signal_d, exp_ready, exp_dv, exp_sync, last_ch, last_d);
      end
    end
    rst   = 1'b0;
    fr_dv = 1'b0;
    mute  = 1'b0;
  endtask

  // One channel, no gap: accept, emit, accept, emit ... from the first cycle
  // after reset release; every pulse carries sync and channel 0.
  task automatic test_single_channel();
    logic [W-1:0] prev, held, e_d;
    bit e_ready, e_dv;
    begin_cycle();
    rst = 1'b1;
    model_cycle();
    prev = '0;
    held = '0;
    for (int j = 0; j < 20; j++) begin
      begin_cycle();
      rst    = 1'b0;
      fr_dv1 = 1'b1;
      fr_d1  = W'($urandom());
      model_cycle();
      e_ready = (j % 2 == 0);
      e_dv    = (j % 2 == 1);
      if (e_dv) held = prev;
      e_d = held;
      n_checks++;
      if ({fr_ready1, dv1, sync1, ch1, d1} !== {e_ready, e_dv, e_dv, 1'b0, e_d}) begin
        n_errors++;
        $display("FAIL single_channel j=%0d got rdy=%b dv=%b sync=%b ch=%0d d=%h expected rdy=%b dv=%b sync=%b ch=0 d=%h",
                 j, fr_ready1, dv1, sync1, ch1, d1, e_ready, e_dv, e_dv, e_d);
      end
      prev = fr_d1;
    end
    fr_dv1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_back_to_back();
    test_mute();
    test_reset_mid_frame();
    test_ignore_dv();
    test_random();
    test_single_channel();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter NR_CHANNELS, default 3: channels per frame, minimum 1.
REQ-002 SHALL have parameter INPUT_WIDTH, default 24: bits per sample.
REQ-003 SHALL have parameter SYNC_INTERVAL, default 3: frames per vm_sync pulse, minimum 1.
REQ-004 SHALL have parameter DV_GAP, default 1: idle cycles after every vm_signal_dv pulse, minimum 0.
REQ-005 SHALL define CHW = 1 when NR_CHANNELS < 2, otherwise $clog2(NR_CHANNELS).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port fr_d, input, NR_CHANNELS*INPUT_WIDTH bits: one parallel frame, channel k at bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 SHALL have port fr_dv, input, 1 bit: frame valid.
REQ-010 SHALL have port fr_ready, output, 1 bit: frame accept.
REQ-011 SHALL have port mute, input, 1 bit: zero the outgoing sample data.
REQ-012 SHALL have port vm_signal_d, output, INPUT_WIDTH bits: serialized signed sample.
REQ-013 SHALL have port vm_signal_ch, output, CHW bits: channel index of the sample.
REQ-014 SHALL have port vm_signal_dv, output, 1 bit: sample valid, single-cycle pulse.
REQ-015 SHALL have port vm_sync, output, 1 bit: metering-period sync pulse.

Function
REQ-016 SHALL implement FSM states IDLE, EMIT and GAP; fr_ready SHALL be high only in IDLE (combinational from state).
REQ-017 SHALL capture fr_d into a frame buffer when fr_dv and fr_ready are both high, then enter EMIT; fr_dv while fr_ready is low SHALL be ignored and the buffer left unchanged.
REQ-018 SHALL assert vm_signal_dv for channel k, with vm_signal_ch = k, at cycle A+1+k*(1+DV_GAP), where A is the acceptance cycle.
REQ-019 SHALL hold vm_signal_d and vm_signal_ch at their last emitted values between pulses.
REQ-020 SHALL wait DV_GAP cycles in GAP between samples and after the last channel; with DV_GAP = 0 it SHALL skip GAP and go directly to EMIT or IDLE.
REQ-021 SHALL give a minimum frame period of NR_CHANNELS*(1+DV_GAP)+1 cycles under continuous fr_dv.
REQ-022 SHALL keep a frame counter that increments on each last-channel emission and wraps to 0 after reaching SYNC_INTERVAL-1.
REQ-023 SHALL pulse vm_sync for one cycle, coincident with the last-channel vm_signal_dv, when the counter is at SYNC_INTERVAL-1; with SYNC_INTERVAL = 1, vm_sync SHALL pulse on every frame.
REQ-024 SHALL emit vm_signal_d as a bit-exact copy of the buffered sample, with no arithmetic and no sign change.

Reset
REQ-025 SHALL, while rst is high, immediately force fr_ready=0, vm_signal_d=0, vm_signal_ch=0, vm_signal_dv=0, vm_sync=0, the frame counter to 0, the buffer to 0 and the state to IDLE.
REQ-026 SHALL, when rst is asserted mid-frame, discard the frame and issue no further pulses; after release the next accepted frame SHALL start at channel 0 with the frame counter at 0.
REQ-027 SHALL have fr_ready high in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with macro SAMPLE_SERIALIZER_MUTE_EN defined, output vm_signal_d = 0 for any sample emitted while mute is high; vm_signal_dv, vm_signal_ch and vm_sync SHALL be unaffected.
REQ-029 SHALL, without SAMPLE_SERIALIZER_MUTE_EN, keep the mute port but ignore it, passing data unchanged.

Verification
REQ-030 SHALL test: defaults, frame {0x000001, 0x7FFFFF, 0x800000} accepted at A -> pulses at A+1, A+3, A+5 with ch 0, 1, 2 and those exact values.
REQ-031 SHALL test: fr_dv held high for 3 frames, SYNC_INTERVAL=3 -> exactly one vm_sync, at the ch2 pulse of frame 3; fr_ready low throughout every EMIT and GAP cycle.
REQ-032 SHALL test: mute high only during the ch1 pulse -> with macro ch1 data = 0 and ch0/ch2 intact; without macro all data intact.
REQ-033 SHALL test: rst pulsed at the ch1 pulse -> all outputs 0 at once, no ch2 pulse; next frame emits ch0 first and vm_sync appears only after 3 further frames.
REQ-034 SHALL test: fr_dv toggled with a new fr_d during EMIT -> ignored; emitted data equals the originally accepted frame.
REQ-035 SHALL test: NR_CHANNELS=1, DV_GAP=0, SYNC_INTERVAL=1, continuous fr_dv -> vm_signal_dv and vm_sync high every 2nd cycle, vm_signal_ch always 0.
